dff_bank_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares a single WIDTH-bit D flip-flop storage register between two requesters. Each requester raises a request with its data; the block grants one requester at a time, loads that requester's data into the shared register, and completes a four-phase REQ/ACK handshake before serving the next. It sits in front of the lab's D flip-flop register banks, giving two producers contention-free, fairly alternated write access.

---
 rtl/dff_bank_arbiter_pkg.sv | 15 +
 rtl/dff_bank_arbiter_reg_en_sr.sv | 21 ++
 rtl/dff_bank_arbiter.sv | 94 +++++++++
 tb/tb_dff_bank_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the two-requester register arbiter: FSM state
// encodings and the default data width.
package dff_bank_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 2'b11 is never entered on purpose; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ACK  = 2'b10,
    ST_RSVD = 2'b11
  } state_t;

endpackage

// File: rtl/dff_bank_arbiter_reg_en_sr.sv
// WIDTH-bit storage register with synchronous active-high reset and a
// load enable. Reset takes priority over load.
module reg_en_sr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear on reset, otherwise capture d when enabled, else hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer giving two requesters fair,
// exclusive write access to one shared register through a four-phase
// REQ/ACK handshake: IDLE -> LOAD (grant, one cycle) -> ACK (until REQ drops).
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             RE,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY
);

  state_t state, state_next;
  logic   sel, sel_next;   // current owner of the register
  logic   pri, pri_next;   // requester favoured on a simultaneous request

  logic             req_sel;
  logic [WIDTH-1:0] d_sel;

  assign req_sel = sel ? REQ1 : REQ0;
  assign d_sel   = sel ? D1   : D0;

  // State, owner and priority registers; reset wins over every transition.
  always_ff @(posedge C) begin
    if (RE) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      pri   <= 1'b0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      pri   <= pri_next;
    end
  end

  // Next-state logic: pick an owner in IDLE, flip priority after each load.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    sel_next   = sel;
    pri_next   = pri;
    unique case (state)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          sel_next   = pri;
          state_next = ST_LOAD;
        end else if (REQ0) begin
          sel_next   = 1'b0;
          state_next = ST_LOAD;
        end else if (REQ1) begin
          sel_next   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pri_next   = ~sel;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        if (!req_sel) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore output decode from state and owner; the reserved code asserts
  // nothing, including BUSY.
  assign GNT0 = (state == ST_LOAD) && !sel;
  assign GNT1 = (state == ST_LOAD) &&  sel;
  assign ACK0 = (state == ST_ACK)  && !sel;
  assign ACK1 = (state == ST_ACK)  &&  sel;
  assign BUSY = (state == ST_LOAD) || (state == ST_ACK);

  // Shared register: written only at the end of LOAD with the owner's data.
  reg_en_sr #(.WIDTH(WIDTH)) u_reg (
    .clk (C),
    .rst (RE),
    .en  (state == ST_LOAD),
    .d   (d_sel),
    .q   (Q)
  );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter. Expected register values are
// pushed to a scoreboard when a request is driven and popped on its ACK.
module tb_dff_bank_arbiter;

  logic       C = 1'b0;
  logic       RE;
  logic       REQ0, REQ1;
  logic [3:0] D0, D1;
  logic       GNT0, GNT1, ACK0, ACK1, BUSY;
  logic [3:0] Q;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] sb[$];

  // handshake vector {GNT0, GNT1, ACK0, ACK1, BUSY}
  localparam logic [4:0] HS_IDLE = 5'b00000;
  localparam logic [4:0] HS_GNT0 = 5'b10001;
  localparam logic [4:0] HS_GNT1 = 5'b01001;
  localparam logic [4:0] HS_ACK0 = 5'b00101;
  localparam logic [4:0] HS_ACK1 = 5'b00011;

  dff_bank_arbiter #(.WIDTH(4)) dut (
    .C    (C),
    .RE   (RE),
    .REQ0 (REQ0),
    .D0   (D0),
    .REQ1 (REQ1),
    .D1   (D1),
    .GNT0 (GNT0),
    .GNT1 (GNT1),
    .ACK0 (ACK0),
    .ACK1 (ACK1),
    .Q    (Q),
    .BUSY (BUSY)
  );

  always #5 C = ~C;

  function automatic logic [4:0] hs();
    return {GNT0, GNT1, ACK0, ACK1, BUSY};
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic sb_pop(output logic [3:0] e, output bit ok);
    ok = (sb.size() > 0);
    e  = ok ? sb.pop_front() : 4'hx;
  endtask

  task automatic do_reset();
    RE = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; D0 = 4'h0; D1 = 4'h0;
    tick(); tick();
    RE = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (Q !== 4'h0) begin
      tests_failed++; $display("FAIL reset_q: got %h want %h", Q, 4'h0);
    end
    tests_run++;
    if (hs() !== HS_IDLE) begin
      tests_failed++; $display("FAIL reset_hs: got %b want %b", hs(), HS_IDLE);
    end
    tick();
    tests_run++;
    if (hs() !== HS_IDLE) begin
      tests_failed++; $display("FAIL reset_idle_hold: got %b want %b", hs(), HS_IDLE);
    end
  endtask

  task automatic test_single();
    logic [3:0] e; bit ok;
    REQ0 = 1'b1; D0 = 4'hA; sb.push_back(4'hA);
    tick();
    tests_run++;
    if (hs() !== HS_GNT0 || Q !== 4'h0) begin
      tests_failed++; $display("FAIL single_load: got hs=%b q=%h want hs=%b q=0", hs(), Q, HS_GNT0);
    end
    tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || hs() !== HS_ACK0 || Q !== e) begin
      tests_failed++; $display("FAIL single_ack: got hs=%b q=%h want hs=%b q=%h", hs(), Q, HS_ACK0, e);
    end
    tick();
    tests_run++;
    if (hs() !== HS_ACK0) begin
      tests_failed++; $display("FAIL single_ack_hold: got %b want %b", hs(), HS_ACK0);
    end
    REQ0 = 1'b0;
    tick();
    tests_run++;
    if (hs() !== HS_IDLE || Q !== 4'hA) begin
      tests_failed++; $display("FAIL single_release: got hs=%b q=%h want hs=%b q=a", hs(), Q, HS_IDLE);
    end
  endtask

  task automatic test_tie();
    logic [3:0] e; bit ok;
    do_reset();
    REQ0 = 1'b1; D0 = 4'h3; REQ1 = 1'b1; D1 = 4'hC;
    sb.push_back(4'h3); sb.push_back(4'hC);
    tick();
    tests_run++;
    if (hs() !== HS_GNT0) begin
      tests_failed++; $display("FAIL tie_first_gnt: got %b want %b", hs(), HS_GNT0);
    end
    tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || hs() !== HS_ACK0 || Q !== e) begin
      tests_failed++; $display("FAIL tie_first_ack: got hs=%b q=%h want hs=%b q=%h", hs(), Q, HS_ACK0, e);
    end
    REQ0 = 1'b0;
    tick();
    tests_run++;
    if (hs() !== HS_IDLE) begin
      tests_failed++; $display("FAIL tie_idle: got %b want %b", hs(), HS_IDLE);
    end
    tick();
    tests_run++;
    if (hs() !== HS_GNT1) begin
      tests_failed++; $display("FAIL tie_second_gnt: got %b want %b", hs(), HS_GNT1);
    end
    tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || hs() !== HS_ACK1 || Q !== e) begin
      tests_failed++; $display("FAIL tie_second_ack: got hs=%b q=%h want hs=%b q=%h", hs(), Q, HS_ACK1, e);
    end
    REQ1 = 1'b0;
    tick();
  endtask

  // Both requesters keep re-raising; owners must alternate, starting with 0
  // because requester 1 was served last.
  task automatic test_alternate();
    logic [3:0] e; bit ok;
    logic pri_m;
    logic owner;
    pri_m = 1'b0;
    REQ0 = 1'b1; D0 = 4'h3; REQ1 = 1'b1; D1 = 4'hC;
    for (int i = 0; i < 4; i++) begin
      owner = pri_m;
      sb.push_back(owner ? D1 : D0);
      tick();
      tests_run++;
      if (hs() !== (owner ? HS_GNT1 : HS_GNT0)) begin
        tests_failed++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, hs(), owner ? HS_GNT1 : HS_GNT0);
      end
      tick();
      sb_pop(e, ok);
      tests_run++;
      if (!ok || hs() !== (owner ? HS_ACK1 : HS_ACK0) || Q !== e) begin
        tests_failed++; $display("FAIL alt_ack[%0d]: got hs=%b q=%h want hs=%b q=%h", i, hs(), Q, owner ? HS_ACK1 : HS_ACK0, e);
      end
      if (owner) REQ1 = 1'b0; else REQ0 = 1'b0;
      tick();
      if (owner) REQ1 = 1'b1; else REQ0 = 1'b1;
      pri_m = ~owner;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] e; bit ok;
    do_reset();
    REQ0 = 1'b1; D0 = 4'h5; sb.push_back(4'h5);
    tick(); tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || Q !== e) begin
      tests_failed++; $display("FAIL rml_setup: got q=%h want q=%h", Q, e);
    end
    REQ0 = 1'b0;
    tick();
    REQ1 = 1'b1; D1 = 4'hF;
    tick();
    tests_run++;
    if (hs() !== HS_GNT1) begin
      tests_failed++; $display("FAIL rml_gnt: got %b want %b", hs(), HS_GNT1);
    end
    RE = 1'b1;
    tick();
    tests_run++;
    if (hs() !== HS_IDLE || Q !== 4'h0) begin
      tests_failed++; $display("FAIL rml_cleared: got hs=%b q=%h want hs=%b q=0", hs(), Q, HS_IDLE);
    end
    // priority must be back to requester 0 even though 0 was served last
    RE = 1'b0; REQ0 = 1'b1; D0 = 4'h3; REQ1 = 1'b1; D1 = 4'hC;
    sb.push_back(4'h3);
    tick();
    tests_run++;
    if (hs() !== HS_GNT0) begin
      tests_failed++; $display("FAIL rml_pri: got %b want %b", hs(), HS_GNT0);
    end
    tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || Q !== e) begin
      tests_failed++; $display("FAIL rml_after_q: got q=%h want q=%h", Q, e);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick(); tick();
    tests_run++;
    if (hs() !== HS_IDLE) begin
      tests_failed++; $display("FAIL rml_idle: got %b want %b", hs(), HS_IDLE);
    end
  endtask

  task automatic test_drop_in_load();
    logic [3:0] e; bit ok;
    REQ1 = 1'b1; D1 = 4'h6; sb.push_back(4'h6);
    tick();
    tests_run++;
    if (hs() !== HS_GNT1) begin
      tests_failed++; $display("FAIL dil_gnt: got %b want %b", hs(), HS_GNT1);
    end
    REQ1 = 1'b0;
    tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || hs() !== HS_ACK1 || Q !== e) begin
      tests_failed++; $display("FAIL dil_ack: got hs=%b q=%h want hs=%b q=%h", hs(), Q, HS_ACK1, e);
    end
    tick();
    tests_run++;
    if (hs() !== HS_IDLE || Q !== 4'h6) begin
      tests_failed++; $display("FAIL dil_pulse: got hs=%b q=%h want hs=%b q=6", hs(), Q, HS_IDLE);
    end
  endtask

  task automatic test_data_hold();
    logic [3:0] e; bit ok;
    REQ0 = 1'b1; D0 = 4'h1; sb.push_back(4'h1);
    tick(); tick();
    sb_pop(e, ok);
    tests_run++;
    if (!ok || hs() !== HS_ACK0 || Q !== e) begin
      tests_failed++; $display("FAIL hold_ack: got hs=%b q=%h want hs=%b q=%h", hs(), Q, HS_ACK0, e);
    end
    D0 = 4'h9;
    tick(); tick();
    tests_run++;
    if (hs() !== HS_ACK0 || Q !== 4'h1) begin
      tests_failed++; $display("FAIL hold_q: got hs=%b q=%h want hs=%b q=1", hs(), Q, HS_ACK0);
    end
    REQ0 = 1'b0;
    tick();
    tests_run++;
    if (hs() !== HS_IDLE || Q !== 4'h1) begin
      tests_failed++; $display("FAIL hold_idle: got hs=%b q=%h want hs=%b q=1", hs(), Q, HS_IDLE);
    end
  endtask

  initial begin
    RE = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; D0 = 4'h0; D1 = 4'h0;
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_reset_mid_load();
    test_drop_in_load();
    test_data_hold();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
